// File: rtl/display_pkg.sv
// Shared types and constants for the result display stage: FSM states,
// page indices, fixed segment patterns and the page-to-halfword selector.
package display_pkg;

   typedef enum logic [1:0] {LOAD, WAIT, SHOW} state_t;

   typedef logic [2:0] page_t;

   localparam page_t R_LO      = 3'd0;
   localparam page_t R_HI      = 3'd1;
   localparam page_t A_LO      = 3'd2;
   localparam page_t A_HI      = 3'd3;
   localparam page_t B_LO      = 3'd4;
   localparam page_t B_HI      = 3'd5;
   localparam page_t NUM_PAGES = 3'd6;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Unused indices fall back to R[15:0], matching the forced page 0.
   function automatic logic [15:0] page_half(input page_t pg,
                                             input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] r);
      logic [15:0] h;
      case (pg)
         R_LO:    h = r[15:0];
         R_HI:    h = r[31:16];
         A_LO:    h = a[15:0];
         A_HI:    h = a[31:16];
         B_LO:    h = b[15:0];
         B_HI:    h = b[31:16];
         default: h = r[15:0];
      endcase
      return h;
   endfunction

endpackage

// File: rtl/result_display_if.sv
// Operand/result inputs, operator button and digit outputs of the display stage.
interface result_display_if;
   logic        enter;
   logic        loaddata;
   logic        inputdata_ready;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic [31:0] dataR;
   logic [6:0]  disp3;
   logic [6:0]  disp2;
   logic [6:0]  disp1;
   logic [6:0]  disp0;
   logic [2:0]  page;

   modport master (
      output enter, loaddata, inputdata_ready, dataA, dataB, dataR,
      input  disp3, disp2, disp1, disp0, page
   );

   modport slave (
      input  enter, loaddata, inputdata_ready, dataA, dataB, dataR,
      output disp3, disp2, disp1, disp0, page
   );
endinterface

// File: rtl/seg7_hex.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module seg7_hex (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   always_comb begin
      seg = 7'b1111111;
      case (nibble)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
   end
endmodule

// File: rtl/result_display.sv
// Display stage: debounces the enter button, snapshots A/B/R on entry to
// SHOW and pages through their 16-bit halves on the four hex digits.
module result_display
   import display_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input logic             clk,
   input logic             reset,
   result_display_if.slave bus
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1, sync2, deb, deb_d, press, armed;
   logic [1:0]    settle;
   logic [CW-1:0] cnt;

   state_t        state, state_next;
   page_t         page_q, page_next;
   logic [31:0]   snap_a, snap_b, snap_r;
   logic [31:0]   snap_a_next, snap_b_next, snap_r_next;
   logic [15:0]   half;
   logic [3:0][6:0] hex_seg, disp_next, disp_q;

   // A button already held through reset must be released before it can
   // produce a press; arming waits until the synchroniser has refilled.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         deb    <= 1'b0;
         deb_d  <= 1'b0;
         press  <= 1'b0;
         cnt    <= '0;
         settle <= '0;
         armed  <= 1'b0;
      end else begin
         sync1 <= bus.enter;
         sync2 <= sync1;
         if (sync2 == deb) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb <= ~deb;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
         deb_d <= deb;
         press <= armed & deb & ~deb_d;
         if (settle != 2'd2) settle <= settle + 2'd1;
         if (settle == 2'd2 && !sync1 && !sync2 && !deb) armed <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= LOAD;
         page_q <= R_LO;
         snap_a <= '0;
         snap_b <= '0;
         snap_r <= '0;
         disp_q <= {4{SEG_BLANK}};
      end else begin
         state  <= state_next;
         page_q <= page_next;
         snap_a <= snap_a_next;
         snap_b <= snap_b_next;
         snap_r <= snap_r_next;
         disp_q <= disp_next;
      end
   end

   always_comb begin
      state_next  = state;
      page_next   = page_q;
      snap_a_next = snap_a;
      snap_b_next = snap_b;
      snap_r_next = snap_r;
      if (bus.loaddata) begin
         state_next = LOAD;
         page_next  = R_LO;
      end else if (state != SHOW) begin
         page_next = R_LO;
         if (bus.inputdata_ready) begin
            state_next  = SHOW;
            snap_a_next = bus.dataA;
            snap_b_next = bus.dataB;
            snap_r_next = bus.dataR;
         end else begin
            state_next = WAIT;
         end
      end else if (page_q >= NUM_PAGES) begin
         page_next = R_LO;
      end else if (press) begin
         page_next = (page_q == B_HI) ? R_LO : page_q + 3'd1;
      end
   end

   // Digits are decoded from next-state values so they register together with page.
   assign half = page_half(page_next, snap_a_next, snap_b_next, snap_r_next);

   seg7_hex u_hex0 (.nibble(half[3:0]),   .seg(hex_seg[0]));
   seg7_hex u_hex1 (.nibble(half[7:4]),   .seg(hex_seg[1]));
   seg7_hex u_hex2 (.nibble(half[11:8]),  .seg(hex_seg[2]));
   seg7_hex u_hex3 (.nibble(half[15:12]), .seg(hex_seg[3]));

   always_comb begin
      disp_next = {4{SEG_BLANK}};
      case (state_next)
         LOAD:    disp_next = {4{SEG_DASH}};
         SHOW:    disp_next = hex_seg;
         default: disp_next = {4{SEG_BLANK}};
      endcase
   end

   assign bus.disp0 = disp_q[0];
   assign bus.disp1 = disp_q[1];
   assign bus.disp2 = disp_q[2];
   assign bus.disp3 = disp_q[3];
   assign bus.page  = page_q;

endmodule

// File: doc/result_display.md
# result_display

Display-side stage downstream of the peripherals operand loader: consumes the assembled operands `dataA`/`dataB`, the ALU result `dataR`, and the operator's `enter` button, and drives the four 7-segment digits. On leaving load mode it snapshots A, B and R, then steps through six 16-bit pages (R low/high, A low/high, B low/high) on each debounced `enter` press. It owns its own button synchroniser/debouncer so that it is independent of the loader's pulse logic.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required to accept a level change on `enter`; range 1..2^20.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `enter`  in  1  raw push-button level, asynchronous to `clk`, active-high.
- `loaddata`  in  1  1 = operand load mode (loader owns `enter`); 0 = display mode.
- `inputdata_ready`  in  1  loader flag: A and B complete.
- `dataA`, `dataB`  in  32  operands from the loader.
- `dataR`  in  32  result word.
- `disp3..disp0`  out  7  digit segments, active-low, bit order {g,f,e,d,c,b,a}; `disp3` is the most significant nibble.
- `page`  out  3  current page index, for debug and bench visibility.

## Operation
- Button path: 2-FF synchroniser, then debounce counter. The counter resets whenever the synchronised level equals the debounced level. The debounced level flips after `DEBOUNCE_CYCLES` consecutive differing samples. A rising edge of the debounced level yields a 1-cycle `press` strobe.
- FSM states:
  - LOAD: entered on reset or whenever `loaddata`=1. Has priority over every other transition.
  - WAIT: `loaddata`=0, `inputdata_ready`=0.
  - SHOW: `loaddata`=0, `inputdata_ready`=1.
- Transitions:
  - LOAD→WAIT when `loaddata`=0 and `inputdata_ready`=0.
  - LOAD/WAIT→SHOW when `loaddata`=0 and `inputdata_ready`=1. On this edge, `dataA`/`dataB`/`dataR` are latched into snapshot registers and `page`=0.
  - SHOW→LOAD when `loaddata`=1.
- Pages in SHOW: 0=R[15:0], 1=R[31:16], 2=A[15:0], 3=A[31:16], 4=B[15:0], 5=B[31:16].
  - A `press` in SHOW advances `page`; 5 wraps to 0.
  - Indices 6 and 7 never occur; if reached, force `page` to 0.
- Digit content:
  - SHOW: nibble i of the selected half goes to `disp<i>`, hex decoded.
  - LOAD: all digits show dash (7'b0111111).
  - WAIT: all digits blank (7'b1111111).
- Snapshots hold while in SHOW. Input changes are ignored until the next entry into SHOW.
- `press` in LOAD or WAIT is discarded and is not queued.

## Timing
- Reset values:
  - `page`=0; digits blank (7'b1111111) in the cycle reset is asserted.
  - After release, state=LOAD and digits show dash from the first post-reset edge.
  - Synchroniser, debounced level, counter and snapshots all reset to 0.
- Outputs are registered. `disp*` reflects state/page in the same cycle that `page` updates.
- Press latency: `enter` held high from edge N means `page` increments at edge N+DEBOUNCE_CYCLES+3. Breakdown: 2 sync, DEBOUNCE_CYCLES count, 1 press, 1 page.
- Pulses shorter than DEBOUNCE_CYCLES synchronised cycles are rejected. A continuous hold gives exactly one advance. The release must also be debounced before the next press is accepted.
- SHOW entry to first display of R[15:0]: one edge.
- `loaddata` rising and `press` in the same cycle: go to LOAD, no advance.
- Reset mid-SHOW: next edge clears to LOAD with `page`=0. The debouncer also clears, so a held button produces a press only after release and re-press.

## Structure
- Package `display_pkg`:
  - state enum {LOAD, WAIT, SHOW}
  - page constants R_LO..B_HI and `NUM_PAGES`=6
  - `SEG_BLANK` 7'b1111111, `SEG_DASH` 7'b0111111
- Sub-module `seg7_hex`: combinational 4-bit→7-bit active-low decoder, instantiated four times. Examples: 0→7'b1000000, 8→7'b0000000, F→7'b0001110.
- Debouncer and edge detector stay inline. Target size is about 200 lines including the package.

## Test plan
- Reset, then `loaddata`=1 → all `disp*`=7'b0111111, `page`=0. Pulse `enter` for 8 cycles → no change.
- `dataA`=32'h3F800000, `dataB`=32'hA1BE867D, `dataR`=32'hC2820000, `inputdata_ready`=1, drop `loaddata` → next edge shows "0000" (all 7'b1000000), `page`=0.
- Six presses of 8 cycles each, 8 cycles apart, DEBOUNCE_CYCLES=4 → pages 1..5 then 0. Page 1 shows C,2,8,2; page 3 shows 3,F,8,0; page 4 shows 8,6,7,D. Each advance occurs exactly 7 edges after `enter` rises.
- 2-cycle glitches on `enter` in SHOW → `page` unchanged. Change `dataR` to 32'h12345678 mid-SHOW → display unchanged (snapshot held).
- `loaddata`=0 with `inputdata_ready`=0 → blank digits. Raise `inputdata_ready` → SHOW at `page`=0.
- `loaddata` rises in the same cycle as a press strobe → LOAD, dashes, `page`=0. Assert `reset` mid-press → LOAD, and no press until release and re-press.
